// File: rtl/exe_stage_pkg.sv
// Shared types and constants for the ARM execute stage: widths, ALU command
// codes, shifter types, NZCV bit positions and a rotate helper.
package exe_stage_pkg;

    localparam int EXE_DATA_W = 32;
    localparam int EXE_REG_AW = 4;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Rotate right via a doubled word so an amount of 0 needs no special case.
    function automatic logic [EXE_DATA_W-1:0] ror_w(input logic [EXE_DATA_W-1:0] x,
                                                    input logic [4:0]            n);
        logic [2*EXE_DATA_W-1:0] t;
        t = {x, x} >> n;
        return t[EXE_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID->EXE->MEM signal bundle for the execute stage. With EXE_FORWARDING_EN
// defined it also carries the operand-forwarding selects and values.
interface exe_stage_if
    import exe_stage_pkg::*;
#(
    parameter int DATA_W = EXE_DATA_W,
    parameter int REG_AW = EXE_REG_AW
);
    logic              mem_ready;
    logic              valid_in;
    logic              wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm_in;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] val_Rn, val_Rm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [DATA_W-1:0] pc_in;
    logic [REG_AW-1:0] dest_in;
`ifdef EXE_FORWARDING_EN
    logic [1:0]        sel_src1, sel_src2;
    logic [DATA_W-1:0] mem_fwd_val, wb_fwd_val;
`endif

    logic              wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [DATA_W-1:0] alu_res_out;
    logic [DATA_W-1:0] val_Rm_out;
    logic [REG_AW-1:0] dest_out;
    logic [3:0]        status_out;
    logic [DATA_W-1:0] branch_address;
    logic              stall_out;

    modport slave (
        input  mem_ready, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm_in,
               exe_cmd, val_Rn, val_Rm, shift_operand, signed_imm_24, pc_in, dest_in,
`ifdef EXE_FORWARDING_EN
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
`endif
        output wb_en_out, mem_r_en_out, mem_w_en_out, alu_res_out, val_Rm_out,
               dest_out, status_out, branch_address, stall_out
    );

    modport master (
        output mem_ready, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm_in,
               exe_cmd, val_Rn, val_Rm, shift_operand, signed_imm_24, pc_in, dest_in,
`ifdef EXE_FORWARDING_EN
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
`endif
        input  wb_en_out, mem_r_en_out, mem_w_en_out, alu_res_out, val_Rm_out,
               dest_out, status_out, branch_address, stall_out
    );

endinterface

// File: rtl/exe_stage_val2_generator.sv
// Second-operand builder: rotated 8-bit immediate, 12-bit memory offset, or
// the Rm register passed through the barrel shifter.
module val2_generator
    import exe_stage_pkg::*;
#(
    parameter int DATA_W = EXE_DATA_W
) (
    input  logic              imm_i,
    input  logic              mem_i,
    input  logic [DATA_W-1:0] rm_i,
    input  logic [11:0]       shop_i,
    output logic [DATA_W-1:0] val2_o
);
    logic [4:0] amt;
    logic [1:0] sh;

    assign amt = shop_i[11:7];
    assign sh  = shop_i[6:5];

    always_comb begin
        val2_o = rm_i;
        if (imm_i) begin
            val2_o = ror_w({{(DATA_W-8){1'b0}}, shop_i[7:0]}, {shop_i[11:8], 1'b0});
        end else if (mem_i) begin
            val2_o = {{(DATA_W-12){1'b0}}, shop_i};
        end else begin
            case (sh)
                SH_LSL:  val2_o = rm_i << amt;
                SH_LSR:  val2_o = rm_i >> amt;
                SH_ASR:  val2_o = $signed(rm_i) >>> amt;
                default: val2_o = ror_w(rm_i, amt);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: ALU, NZCV register, branch target and the EXE->MEM
// pipeline register, frozen while MEM is not ready. EXE_FORWARDING_EN adds operand forwarding.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DATA_W = EXE_DATA_W,
    parameter int REG_AW = EXE_REG_AW
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);
    logic [DATA_W-1:0] rn, rm, val2, res_d;
    logic [3:0]        status_q, status_d;
    logic              is_mem, cap;

    logic              wb_en_q, mem_r_en_q, mem_w_en_q;
    logic [DATA_W-1:0] alu_res_q, val_rm_q;
    logic [REG_AW-1:0] dest_q;

`ifdef EXE_FORWARDING_EN
    always_comb begin
        case (bus.sel_src1)
            2'b01:   rn = bus.mem_fwd_val;
            2'b10:   rn = bus.wb_fwd_val;
            default: rn = bus.val_Rn;
        endcase
        case (bus.sel_src2)
            2'b01:   rm = bus.mem_fwd_val;
            2'b10:   rm = bus.wb_fwd_val;
            default: rm = bus.val_Rm;
        endcase
    end
`else
    assign rn = bus.val_Rn;
    assign rm = bus.val_Rm;
`endif

    assign is_mem = bus.mem_r_en_in | bus.mem_w_en_in;
    assign cap    = bus.mem_ready;

    val2_generator #(.DATA_W(DATA_W)) u_val2 (
        .imm_i  (bus.imm_in),
        .mem_i  (is_mem),
        .rm_i   (rm),
        .shop_i (bus.shift_operand),
        .val2_o (val2)
    );

    logic [3:0]        cmd;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] bp;
    logic              cin, arith, upd;

    // Address generation for loads/stores is always an add, whatever ID decoded.
    always_comb begin
        cmd      = is_mem ? CMD_ADD : bus.exe_cmd;
        bp       = val2;
        cin      = 1'b0;
        arith    = 1'b0;
        upd      = 1'b1;
        res_d    = '0;
        case (cmd)
            CMD_MOV: res_d = val2;
            CMD_MVN: res_d = ~val2;
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = status_q[FLAG_C]; end
            CMD_SUB: begin arith = 1'b1; bp = ~val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; bp = ~val2; cin = status_q[FLAG_C]; end
            CMD_AND: res_d = rn & val2;
            CMD_ORR: res_d = rn | val2;
            CMD_EOR: res_d = rn ^ val2;
            default: upd = 1'b0;
        endcase
        sum = {1'b0, rn} + {1'b0, bp} + {{DATA_W{1'b0}}, cin};
        if (arith) res_d = sum[DATA_W-1:0];

        status_d = status_q;
        if (upd) begin
            status_d[FLAG_N] = res_d[DATA_W-1];
            status_d[FLAG_Z] = (res_d == '0);
            if (arith) begin
                status_d[FLAG_C] = sum[DATA_W];
                status_d[FLAG_V] = (rn[DATA_W-1] == bp[DATA_W-1]) &&
                                   (res_d[DATA_W-1] != rn[DATA_W-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
            status_q   <= '0;
        end else if (cap) begin
            wb_en_q    <= bus.valid_in & bus.wb_en_in;
            mem_r_en_q <= bus.valid_in & bus.mem_r_en_in;
            mem_w_en_q <= bus.valid_in & bus.mem_w_en_in;
            alu_res_q  <= res_d;
            val_rm_q   <= rm;
            dest_q     <= bus.dest_in;
            if (bus.s_in && bus.valid_in) status_q <= status_d;
        end
    end

    assign bus.wb_en_out      = wb_en_q;
    assign bus.mem_r_en_out   = mem_r_en_q;
    assign bus.mem_w_en_out   = mem_w_en_q;
    assign bus.alu_res_out    = alu_res_q;
    assign bus.val_Rm_out     = val_rm_q;
    assign bus.dest_out       = dest_q;
    assign bus.status_out     = status_q;
    assign bus.stall_out      = ~bus.mem_ready;
    assign bus.branch_address = bus.pc_in +
                                {{(DATA_W-26){bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Directed test for exe_stage: ALU/flags, shifter, memory addressing, freeze,
// bubbles, branch target and asynchronous reset.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    exe_stage_if bus ();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic wb, input logic mr, input logic mw,
                       input logic s, input logic imm, input logic [3:0] cmd,
                       input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] sop);
        bus.valid_in      = v;
        bus.wb_en_in      = wb;
        bus.mem_r_en_in   = mr;
        bus.mem_w_en_in   = mw;
        bus.s_in          = s;
        bus.imm_in        = imm;
        bus.exe_cmd       = cmd;
        bus.val_Rn        = rn;
        bus.val_Rm        = rm;
        bus.shift_operand = sop;
    endtask

    initial begin
        bus.mem_ready     = 1'b1;
        bus.pc_in         = '0;
        bus.signed_imm_24 = '0;
        bus.dest_in       = '0;
        drv(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 12'h000);
        #2;
        chk("reset_alu", bus.alu_res_out, 32'h0);
        chk("reset_status", {28'h0, bus.status_out}, 32'h0);
        chk("reset_wb", {31'h0, bus.wb_en_out}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ADDS imm: 5 + 10
        bus.dest_in = 4'd3;
        drv(1, 1, 0, 0, 1, 1, CMD_ADD, 32'd5, 32'd0, 12'h00A);
        tick();
        chk("add_imm_res", bus.alu_res_out, 32'd15);
        chk("add_imm_status", {28'h0, bus.status_out}, 32'h0);
        chk("add_imm_wb", {31'h0, bus.wb_en_out}, 32'h1);
        chk("add_imm_dest", {28'h0, bus.dest_out}, 32'd3);

        drv(1, 1, 0, 0, 1, 0, CMD_SUB, 32'd3, 32'd5, 12'h000);
        tick();
        chk("subs_res", bus.alu_res_out, 32'hFFFFFFFE);
        chk("subs_status", {28'h0, bus.status_out}, 32'h8);

        drv(1, 1, 0, 0, 0, 0, CMD_ADC, 32'd1, 32'd1, 12'h000);
        tick();
        chk("adc_c0_res", bus.alu_res_out, 32'd2);
        chk("adc_s0_status", {28'h0, bus.status_out}, 32'h8);

        drv(1, 1, 0, 0, 1, 0, CMD_ADD, 32'h7FFFFFFF, 32'd1, 12'h000);
        tick();
        chk("adds_ovf_res", bus.alu_res_out, 32'h80000000);
        chk("adds_ovf_status", {28'h0, bus.status_out}, 32'h9);

        drv(1, 1, 0, 0, 1, 0, CMD_ADD, 32'hFFFFFFFF, 32'd1, 12'h000);
        tick();
        chk("adds_carry_res", bus.alu_res_out, 32'h0);
        chk("adds_carry_status", {28'h0, bus.status_out}, 32'h6);

        drv(1, 1, 0, 0, 0, 0, CMD_ADC, 32'd1, 32'd1, 12'h000);
        tick();
        chk("adc_c1_res", bus.alu_res_out, 32'd3);

        drv(1, 1, 0, 0, 0, 0, CMD_SBC, 32'd10, 32'd3, 12'h000);
        tick();
        chk("sbc_c1_res", bus.alu_res_out, 32'd7);

        drv(1, 1, 0, 0, 0, 0, CMD_MOV, 32'd0, 32'h80000000, {5'd4, 2'b10, 5'b0});
        tick();
        chk("mov_asr_res", bus.alu_res_out, 32'hF8000000);

        drv(1, 1, 0, 0, 0, 1, CMD_MOV, 32'd0, 32'd0, 12'h1FF);
        tick();
        chk("mov_imm_rot", bus.alu_res_out, 32'hC000003F);

        drv(1, 1, 0, 0, 0, 0, CMD_MVN, 32'd0, 32'h0000000F, {5'd4, 2'b00, 5'b0});
        tick();
        chk("mvn_lsl_res", bus.alu_res_out, 32'hFFFFFF0F);

        // ANDS keeps C/V from the previous 0110
        drv(1, 1, 0, 0, 1, 0, CMD_AND, 32'h0000F0F0, 32'h00000FF0, 12'h000);
        tick();
        chk("ands_res", bus.alu_res_out, 32'h000000F0);
        chk("ands_status", {28'h0, bus.status_out}, 32'h2);

        // Load decoded as SUB still adds the zero-extended offset
        drv(1, 1, 1, 0, 0, 0, CMD_SUB, 32'h100, 32'hDEADBEEF, 12'h804);
        tick();
        chk("ldr_addr", bus.alu_res_out, 32'h904);
        chk("ldr_mem_r", {31'h0, bus.mem_r_en_out}, 32'h1);

        drv(1, 0, 0, 1, 0, 0, CMD_ADD, 32'h200, 32'h12345678, 12'h010);
        tick();
        chk("str_addr", bus.alu_res_out, 32'h210);
        chk("str_data", bus.val_Rm_out, 32'h12345678);
        chk("str_ctl", {29'h0, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out}, 32'h1);

        drv(1, 1, 0, 0, 1, 0, 4'b0000, 32'd7, 32'd7, 12'h000);
        tick();
        chk("undef_res", bus.alu_res_out, 32'h0);
        chk("undef_status", {28'h0, bus.status_out}, 32'h2);

        bus.pc_in = 32'h1000;
        bus.signed_imm_24 = 24'hFFFFFF;
        #1;
        chk("br_neg", bus.branch_address, 32'h00000FFC);
        bus.signed_imm_24 = 24'h000010;
        #1;
        chk("br_pos", bus.branch_address, 32'h00001040);

        // Freeze for three edges while SUBS 4-9 waits
        bus.mem_ready = 1'b0;
        drv(1, 1, 0, 0, 1, 0, CMD_SUB, 32'd4, 32'd9, 12'h000);
        #1;
        chk("stall_hi", {31'h0, bus.stall_out}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze_res", bus.alu_res_out, 32'h0);
            chk("freeze_status", {28'h0, bus.status_out}, 32'h2);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("stall_lo", {31'h0, bus.stall_out}, 32'h0);
        tick();
        chk("unfreeze_res", bus.alu_res_out, 32'hFFFFFFFB);
        chk("unfreeze_status", {28'h0, bus.status_out}, 32'h8);

        drv(0, 1, 1, 1, 1, 0, CMD_ADD, 32'd1, 32'd1, 12'h000);
        tick();
        chk("bubble_ctl", {29'h0, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out}, 32'h0);
        chk("bubble_status", {28'h0, bus.status_out}, 32'h8);

        // Async reset asserted in the middle of a freeze
        drv(1, 1, 0, 0, 1, 0, CMD_ADD, 32'h7FFFFFFF, 32'd1, 12'h000);
        bus.dest_in = 4'd5;
        tick();
        chk("pre_rst_status", {28'h0, bus.status_out}, 32'h9);
        bus.mem_ready = 1'b0;
        tick();
        rst = 1'b0;
        #2;
        chk("rst_mid_res", bus.alu_res_out, 32'h0);
        chk("rst_mid_status", {28'h0, bus.status_out}, 32'h0);
        chk("rst_mid_wb", {31'h0, bus.wb_en_out}, 32'h0);
        chk("rst_mid_dest", {28'h0, bus.dest_out}, 32'h0);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.dest_in = 4'd7;
        drv(1, 1, 0, 0, 1, 0, CMD_ADD, 32'hFFFFFFFF, 32'd1, 12'h000);
        tick();
        chk("post_rst_res", bus.alu_res_out, 32'h0);
        chk("post_rst_status", {28'h0, bus.status_out}, 32'h6);
        chk("post_rst_dest", {28'h0, bus.dest_out}, 32'd7);
        chk("post_rst_wb", {31'h0, bus.wb_en_out}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; sits directly upstream of the memory stage and owns the EXE→MEM pipeline register.
- Builds the second operand: immediate rotate, register shift, or the 12-bit memory offset.
- Runs the 32-bit ALU, keeps the NZCV status register, computes the branch target, and freezes while the memory stage reports not-ready.

Parameters:
- DATA_W, 32, datapath/register width.
- REG_AW, 4, register-file address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_ready  in  1  memory stage ready; 0 freezes this stage.
- valid_in  in  1  instruction from ID is valid.
- wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm_in  in  1 each  ID control bits.
- exe_cmd  in  4  ALU command.
- val_Rn, val_Rm  in  DATA_W  operands.
- shift_operand  in  12  ARM shifter operand field.
- signed_imm_24  in  24  branch offset.
- pc_in  in  DATA_W  PC of the instruction.
- dest_in  in  REG_AW  destination register.
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered controls to MEM.
- alu_res_out  out  DATA_W  registered ALU result / memory address.
- val_Rm_out  out  DATA_W  registered store data.
- dest_out  out  REG_AW  registered destination.
- status_out  out  4  NZCV register, N = bit 3.
- branch_address  out  DATA_W  combinational: pc_in + (sign_extend(signed_imm_24) << 2).
- stall_out  out  1  combinational: ~mem_ready, used to freeze IF/ID.

Behaviour:
- Reset (rst = 0, asynchronous): every registered output and status_out are cleared to 0 immediately. Reset asserted mid-freeze also clears.
- Latency: one cycle from ID inputs to registered outputs. The capture edge is a rising clk with mem_ready = 1.
- Freeze: when mem_ready = 0, the pipeline register and status register hold their values. A new instruction presented during the freeze is not captured until the first edge with mem_ready = 1; the inputs are held upstream via stall_out.
- Bubble: valid_in = 0 at capture loads wb_en/mem_r_en/mem_w_en = 0. Data fields load normally (don't-care).
- Val2 selection:
  - imm_in = 1: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - Otherwise, if mem_r_en_in or mem_w_en_in: zero-extended shift_operand[11:0].
  - Otherwise: val_Rm shifted by shift_operand[11:7], type shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 passes val_Rm unchanged.
- exe_cmd encoding:
  - 0001 MOV = val2
  - 1001 MVN = ~val2
  - 0010 ADD = Rn+val2
  - 0011 ADC = Rn+val2+C
  - 0100 SUB/CMP = Rn-val2
  - 0101 SBC = Rn-val2-~C
  - 0110 AND/TST
  - 0111 ORR
  - 1000 EOR
  - Any other code gives result 0 and leaves flags unchanged.
- Arithmetic:
  - Computed at 33 bits. SUB is Rn + ~val2 + 1; SBC is Rn + ~val2 + C.
  - C = bit 32 (ARM not-borrow convention).
  - V = (a[31] == b'[31]) && (r[31] != a[31]), where b' is the effective addend.
  - Logic ops and MOV/MVN update N and Z only; C and V are kept.
- Status update: NZCV is written at a capture edge only when s_in & valid_in & mem_ready. N = r[31], Z = (r == 0).
- ADC/SBC carry source: always the current registered C, never the flag being produced by the same instruction.
- Memory instructions always use ADD, regardless of s_in flag effects.

Optional Feature:
- EXE_FORWARDING_EN defined:
  - Adds inputs sel_src1 and sel_src2 (2 bits each), plus mem_fwd_val and wb_fwd_val (DATA_W each).
  - Select encoding: 00 = register value, 01 = mem_fwd_val, 10 = wb_fwd_val, 11 = register value.
  - sel_src1 replaces val_Rn. sel_src2 replaces val_Rm for both the shifter and the val_Rm_out store data.
- Undefined: those ports are absent and operands come straight from val_Rn/val_Rm.

Decomposition:
- Shared package/defines: DATA_W and REG_AW, exe_cmd codes, shift-type codes, NZCV bit indices.
- One sub-module, val2_generator: combinational shifter/rotator producing val2 from imm_in, the mem flag, val_Rm and shift_operand.

Test Plan:
- ADD imm: Rn = 5, imm_in = 1, shift_operand = 12'h00A, s_in = 1 → next edge alu_res_out = 15, status_out = 4'b0000.
- SUBS 3 - 5 → alu_res_out = 32'hFFFFFFFE, NZCV = 1000. Then ADC 1 + 1 → 2, since C = 0 is used.
- ADDS 32'h7FFFFFFF + 1 → 32'h80000000, NZCV = 1001. ADDS 32'hFFFFFFFF + 1 → 0, NZCV = 0110.
- MOV register ASR: val_Rm = 32'h80000000, shift_operand = {5'd4, 2'b10, 5'b0} → 32'hF8000000. Immediate 12'h1FF → 32'hC000003F.
- Freeze: mem_ready = 0 for 3 cycles while a SUBS is presented → outputs and status_out hold. On mem_ready = 1 the SUBS result and flags appear after one edge. Also check valid_in = 0 yields all-zero controls.
- Async reset pulse mid-freeze → all outputs 0 without a clock edge. First instruction after release is captured normally.
